apb_reg_slave: RTL and testbench

APB_REG_SLAVE -- requirements
Module: apb_reg_slave

---
 rtl/apb_reg_slave.sv | 138 +++++++++++++
 tb/tb_apb_reg_slave.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_reg_slave.sv
// apb_reg_slave: APB completer holding REG_NUM word-indexed registers.
// Registers 0..REG_NUM-2 are read/write with byte strobes. Register REG_NUM-1 is a
// read-only transfer counter that counts successful completions.
// Each access phase is stretched by WAIT_CYCLES wait states.
//
// Ports:
//   PCLK, PRESETn      bus clock, asynchronous active-low reset
//   PADDR              byte address (word index = PADDR >> 2)
//   PSEL, PENABLE      select / access-phase strobes
//   PWRITE             1 = write, 0 = read
//   PWDATA, PSTRB      write data and byte lanes
//   PPROT              protection attributes, accepted and ignored
//   PRDATA             read data, zero outside successful read completions
//   PREADY, PSLVERR    completion and error indicators
//   ctrl_out           live contents of register 0
module apb_reg_slave #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned STROBE_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned REG_NUM      = 8,
    parameter int unsigned WAIT_CYCLES  = 1
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [STROBE_WIDTH-1:0] PSTRB,
    input  logic [2:0]              PPROT,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    output logic [DATA_WIDTH-1:0]   ctrl_out
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int unsigned IDX_W = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
    localparam int unsigned LAST  = REG_NUM - 1;

    typedef enum logic {
        StIdle,
        StAccess
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [DATA_WIDTH-1:0]   r_regs [REG_NUM];

    logic                    w_complete;
    logic [ADDR_WIDTH-1:0]   w_word;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_valid;
    logic                    w_err;
    logic                    w_ok;
    logic                    w_unused;

    assign w_unused = ^PPROT;

    // ---------------- FSM ----------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            StIdle: begin
                if (PSEL && !PENABLE) begin
                    w_state_nxt = StAccess;
                    w_cnt_nxt   = CNT_W'(WAIT_CYCLES);
                end
            end
            StAccess: begin
                if (!PSEL) begin
                    // Abort: drop the transfer without touching any register.
                    w_state_nxt = StIdle;
                    w_cnt_nxt   = '0;
                end else if (PENABLE) begin
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end else begin
                        w_state_nxt = StIdle;
                    end
                end
            end
            default: begin
                w_state_nxt = StIdle;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ---------------- Decode ----------------
    assign w_complete = (r_state == StAccess) && PSEL && PENABLE && (r_cnt == '0);
    assign w_word     = PADDR >> 2;
    assign w_idx      = w_word[IDX_W-1:0];
    assign w_valid    = (PADDR[1:0] == 2'b00) && (w_word < ADDR_WIDTH'(REG_NUM));
    // Writing the counter slot is an error; reading it is fine.
    assign w_err      = w_complete && (!w_valid || (PWRITE && (w_idx == IDX_W'(LAST))));
    assign w_ok       = w_complete && !w_err;

    assign PREADY   = w_complete;
    assign PSLVERR  = w_err;
    assign PRDATA   = (w_ok && !PWRITE) ? r_regs[w_idx] : '0;
    assign ctrl_out = r_regs[0];

    // ---------------- Register file ----------------
    // A successful write never targets LAST, so the strobed write and the counter
    // increment never collide on the same register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_ok) begin
            if (PWRITE) begin
                for (int b = 0; b < STROBE_WIDTH; b++) begin
                    if (PSTRB[b]) begin
                        r_regs[w_idx][8*b +: 8] <= PWDATA[8*b +: 8];
                    end
                end
            end
            r_regs[LAST] <= r_regs[LAST] + DATA_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_apb_reg_slave.sv
// tb_apb_reg_slave: scoreboard bench for apb_reg_slave.
// Instance 0 uses WAIT_CYCLES=1, instance 1 uses WAIT_CYCLES=0; both share the bus
// except for their PSEL lines. A behavioural model per instance predicts read data
// and error flags, which are queued at drive time and popped at completion.
module tb_apb_reg_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        psel0;
    logic        psel1;
    logic        penable;
    logic        pwrite;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;

    logic [31:0] prdata0, prdata1, ctrl0, ctrl1;
    logic        pready0, pready1, pslverr0, pslverr1;

    always #5 clk = ~clk;

    apb_reg_slave #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (32),
        .STROBE_WIDTH(4),
        .REG_NUM     (8),
        .WAIT_CYCLES (1)
    ) u_dut_w1 (
        .PCLK    (clk),
        .PRESETn (rst_n),
        .PADDR   (paddr),
        .PSEL    (psel0),
        .PENABLE (penable),
        .PWRITE  (pwrite),
        .PWDATA  (pwdata),
        .PSTRB   (pstrb),
        .PPROT   (pprot),
        .PRDATA  (prdata0),
        .PREADY  (pready0),
        .PSLVERR (pslverr0),
        .ctrl_out(ctrl0)
    );

    apb_reg_slave #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (32),
        .STROBE_WIDTH(4),
        .REG_NUM     (8),
        .WAIT_CYCLES (0)
    ) u_dut_w0 (
        .PCLK    (clk),
        .PRESETn (rst_n),
        .PADDR   (paddr),
        .PSEL    (psel1),
        .PENABLE (penable),
        .PWRITE  (pwrite),
        .PWDATA  (pwdata),
        .PSTRB   (pstrb),
        .PPROT   (pprot),
        .PRDATA  (prdata1),
        .PREADY  (pready1),
        .PSLVERR (pslverr1),
        .ctrl_out(ctrl1)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_regs [2][8];
    time         last_done [2];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 8; i++) begin
                m_regs[w][i] = '0;
            end
        end
    endtask

    task automatic model_xfer(input int w, input logic [31:0] addr, input logic wr,
                              input logic [31:0] data, input logic [3:0] strb,
                              output exp_t e);
        logic [31:0] word;
        int          idx;
        logic        valid;
        word  = addr >> 2;
        valid = (addr[1:0] == 2'b00) && (word < 32'd8);
        idx   = valid ? int'(word) : 0;
        e.err  = !valid || (wr && idx == 7);
        e.data = '0;
        if (!e.err) begin
            if (!wr) begin
                e.data = m_regs[w][idx];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) m_regs[w][idx][8*b +: 8] = data[8*b +: 8];
                end
            end
            m_regs[w][7] = m_regs[w][7] + 32'd1;
        end
    endtask

    // Entered just after a rising edge; leaves just after the edge that follows
    // completion, with the bus idle, so a following call is back-to-back.
    task automatic xfer(input int w, input logic [31:0] addr, input logic wr,
                        input logic [31:0] data, input logic [3:0] strb,
                        input int exp_cycles);
        exp_t        e;
        exp_t        got;
        int          n;
        logic        rdy;
        logic        er;
        logic [31:0] rd;
        model_xfer(w, addr, wr, data, strb, e);
        sb_q.push_back(e);
        paddr   = addr;
        pwrite  = wr;
        pwdata  = data;
        pstrb   = strb;
        pprot   = 3'($urandom_range(0, 7));
        penable = 1'b0;
        psel0   = (w == 0);
        psel1   = (w == 1);
        @(posedge clk);
        #1 penable = 1'b1;
        n  = 0;
        rd = '0;
        er = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            rdy = (w == 0) ? pready0 : pready1;
            er  = (w == 0) ? pslverr0 : pslverr1;
            rd  = (w == 0) ? prdata0 : prdata1;
            if (rdy) begin
                n = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        check_eq($sformatf("acc_cycles[%0d]@%h", w, addr), 64'(n), 64'(exp_cycles));
        got = sb_q.pop_front();
        check_eq($sformatf("prdata[%0d]@%h", w, addr), 64'(rd), 64'(got.data));
        check_eq($sformatf("pslverr[%0d]@%h", w, addr), 64'(er), 64'(got.err));
        last_done[w] = $time;
        @(posedge clk);
        #1;
        psel0   = 1'b0;
        psel1   = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        time t0;
        logic [31:0] a;
        rst_n   = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        psel0   = 1'b0;
        psel1   = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        pstrb   = '0;
        pprot   = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_pready", 64'(pready0), 64'd0);
        check_eq("rst_ctrl", 64'(ctrl0), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write / read-back, counter from reset
        xfer(0, 32'h0, 1'b1, 32'hA5A5A5A5, 4'hF, 2);
        check_eq("ctrl_after_wr", 64'(ctrl0), 64'hA5A5A5A5);
        xfer(0, 32'h0, 1'b0, 32'h0, 4'h0, 2);
        xfer(0, 32'h4, 1'b1, 32'h11223344, 4'b0101, 2);
        xfer(0, 32'h1C, 1'b0, 32'h0, 4'hF, 2);
        xfer(0, 32'h1C, 1'b0, 32'h0, 4'hF, 2);
        xfer(0, 32'h4, 1'b0, 32'h0, 4'hF, 2);

        // Errors: out of range, misaligned, write to counter
        xfer(0, 32'h20, 1'b0, 32'h0, 4'hF, 2);
        xfer(0, 32'h2, 1'b0, 32'h0, 4'hF, 2);
        xfer(0, 32'h1C, 1'b1, 32'hFFFFFFFF, 4'hF, 2);
        xfer(0, 32'h1C, 1'b0, 32'h0, 4'hF, 2);

        // Abort a write to 0x8 during its wait cycle
        paddr   = 32'h8;
        pwrite  = 1'b1;
        pwdata  = 32'hDEADBEEF;
        pstrb   = 4'hF;
        psel0   = 1'b1;
        penable = 1'b0;
        @(posedge clk);
        #1 penable = 1'b1;
        @(negedge clk);
        check_eq("abort_wait_ready", 64'(pready0), 64'd0);
        @(posedge clk);
        #1;
        psel0   = 1'b0;
        penable = 1'b0;
        @(negedge clk);
        check_eq("abort_ready", 64'(pready0), 64'd0);
        @(posedge clk);
        #1;
        xfer(0, 32'h8, 1'b0, 32'h0, 4'hF, 2);
        xfer(0, 32'h1C, 1'b0, 32'h0, 4'hF, 2);

        // Zero strobe write changes nothing
        xfer(0, 32'h0, 1'b1, 32'h0, 4'h0, 2);
        xfer(0, 32'h0, 1'b0, 32'h0, 4'h0, 2);

        // Random strobed writes, then read every register
        for (int i = 0; i < 8; i++) begin
            a = {27'd0, 3'($urandom_range(0, 6)), 2'b00};
            xfer(0, a, 1'b1, $urandom, 4'($urandom_range(0, 15)), 2);
        end
        for (int i = 0; i < 8; i++) begin
            a = 32'(i * 4);
            xfer(0, a, 1'b0, 32'h0, 4'h0, 2);
        end
        check_eq("ctrl_vs_model", 64'(ctrl0), 64'(m_regs[0][0]));

        // Reset in the middle of a completing read
        paddr   = 32'h0;
        pwrite  = 1'b0;
        psel0   = 1'b1;
        penable = 1'b0;
        @(posedge clk);
        #1 penable = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("pre_rst_ready", 64'(pready0), 64'd1);
        check_eq("pre_rst_prdata", 64'(prdata0), 64'(m_regs[0][0]));
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_pready", 64'(pready0), 64'd0);
        check_eq("mid_rst_pslverr", 64'(pslverr0), 64'd0);
        check_eq("mid_rst_prdata", 64'(prdata0), 64'd0);
        check_eq("mid_rst_ctrl", 64'(ctrl0), 64'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        // Access-phase strobes still high: must not complete without a new setup
        @(negedge clk);
        check_eq("post_rst_ready", 64'(pready0), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("post_rst_ready2", 64'(pready0), 64'd0);
        @(posedge clk);
        #1;
        psel0   = 1'b0;
        penable = 1'b0;
        xfer(0, 32'h0, 1'b0, 32'h0, 4'hF, 2);
        xfer(0, 32'h1C, 1'b0, 32'h0, 4'hF, 2);

        // Zero-wait instance: one access cycle, back-to-back every 2 cycles
        xfer(1, 32'h1C, 1'b0, 32'h0, 4'hF, 1);
        for (int i = 0; i < 3; i++) begin
            t0 = last_done[1];
            xfer(1, 32'h1C, 1'b0, 32'h0, 4'hF, 1);
            check_eq("b2b_period", 64'(last_done[1] - t0), 64'd20);
        end
        xfer(1, 32'h8, 1'b1, 32'hCAFEF00D, 4'b1010, 1);
        xfer(1, 32'h8, 1'b0, 32'h0, 4'h0, 1);
        xfer(1, 32'h0, 1'b1, 32'h5A5A5A5A, 4'hF, 1);
        check_eq("ctrl1", 64'(ctrl1), 64'h5A5A5A5A);
        xfer(1, 32'h1C, 1'b1, 32'h1, 4'hF, 1);
        xfer(1, 32'h1C, 1'b0, 32'h0, 4'hF, 1);

        check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
